// File: rtl/sram_pkg.sv
// Shared types and constants for the external 16-bit asynchronous SRAM interface.
package sram_pkg;

  localparam int SRAM_ADDR_W       = 20;
  localparam int SRAM_DATA_W       = 16;
  localparam int SRAM_WAIT_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } sram_state_t;

endpackage

// File: rtl/sram_read_ctrl.sv
// Timed read/write sequencer for the background-image SRAM; reads win over writes.
// Every pin-facing output is a flop loaded from the next-state decode.
module sram_read_ctrl
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = SRAM_WAIT_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   reading,
  input  logic                   wr_req,
  input  logic [SRAM_ADDR_W-1:0] ADDR,
  input  logic [SRAM_DATA_W-1:0] DATA_WR,
  output logic [SRAM_DATA_W-1:0] DATA_RD,
  output logic                   SRAM_done,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  sram_state_t            state, state_nxt;
  logic [3:0]             wait_cnt;
  logic [SRAM_DATA_W-1:0] wdata_p0;
  logic                   dq_oe;
  logic                   take_req;
  logic                   in_access;
  logic                   last_cycle;

  assign take_req   = (state == IDLE) && (reading || wr_req);
  assign in_access  = (state == RD) || (state == WR);
  assign last_cycle = in_access && (wait_cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (reading)     state_nxt = RD;
        else if (wr_req) state_nxt = WR;
      end
      RD:      if (wait_cnt == 4'd0) state_nxt = DONE;
      WR:      if (wait_cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs: strobes rise together on entry to DONE, address held
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      SRAM_done <= 1'b0;
      dq_oe     <= 1'b0;
      SRAM_ADDR <= '0;
      DATA_RD   <= '0;
    end else begin
      state     <= state_nxt;
      SRAM_CE_N <= !((state_nxt == RD) || (state_nxt == WR));
      SRAM_UB_N <= !((state_nxt == RD) || (state_nxt == WR));
      SRAM_LB_N <= !((state_nxt == RD) || (state_nxt == WR));
      SRAM_OE_N <= (state_nxt != RD);
      SRAM_WE_N <= (state_nxt != WR);
      SRAM_done <= (state_nxt == DONE);
      dq_oe     <= (state_nxt == WR);
      if (take_req) begin
        SRAM_ADDR <= ADDR;
        wait_cnt  <= WAIT_LOAD;
      end else if (in_access && !last_cycle) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if ((state == RD) && last_cycle)
        DATA_RD <= SRAM_DQ;
    end
  end

  // Write data is only meaningful while WR drives the bus
  always_ff @(posedge Clk) begin
    if ((state == IDLE) && !reading && wr_req)
      wdata_p0 <= DATA_WR;
  end

  assign SRAM_DQ = dq_oe ? wdata_p0 : {SRAM_DATA_W{1'bz}};

endmodule

// File: doc/sram_read_ctrl.md
# sram_read_ctrl

Single-port controller for the external 16-bit asynchronous SRAM that holds the background images. It sits directly upstream of the background loader. When the loader raises `reading` with a word address, this block runs a timed read on the SRAM pins, latches the word, and pulses `SRAM_done`. It also provides a write path, so the same SRAM can be filled or patched at run time. Reads have priority over writes.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: number of clock cycles CE/OE (read) or CE/WE (write) stay asserted before the access completes. Legal range 1–15.

Ports:
- `Clk` in 1: system clock. This block has one clock.
- `Reset` in 1: reset, asynchronous and active-high.
- `reading` in 1: read request, level-sensitive. Hold it until `SRAM_done`.
- `wr_req` in 1: write request, level-sensitive. Hold it until `SRAM_done`.
- `ADDR` in 20: word address for the request.
- `DATA_WR` in 16: write data.
- `DATA_RD` out 16: last word read from SRAM. Holds its value between reads.
- `SRAM_done` out 1: one-cycle completion pulse.
- `SRAM_ADDR` out 20: registered address driven to the SRAM.
- `SRAM_DQ` inout 16: SRAM data bus. Driven only in WR state, hi-Z otherwise.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: SRAM controls, active-low.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE
  - All controls inactive (high).
  - If `reading` is high: register `ADDR` into `SRAM_ADDR`, load the wait counter with `WAIT_CYCLES-1`, go to RD.
  - Else if `wr_req` is high: also register `DATA_WR` into the write-data register, then go to WR.
  - If both are high in the same cycle, the read wins. The write stays pending and is taken at the next IDLE.
- RD
  - CE_N, OE_N, UB_N and LB_N are low; DQ is hi-Z.
  - The counter decrements each cycle.
  - In the cycle the counter is 0: capture `SRAM_DQ` into `DATA_RD` at the clock edge and go to DONE.
- WR
  - CE_N, WE_N, UB_N and LB_N are low; DQ is driven from the write-data register.
  - In the cycle the counter is 0: go to DONE.
- DONE
  - `SRAM_done` = 1 and all controls are high.
  - `SRAM_ADDR` is unchanged, so WE rises before the address moves.
  - The next state is always IDLE.
- Request rule: the requester drops its request in the cycle after `SRAM_done`. A request still high when the block returns to IDLE starts a new access using the current `ADDR`. The loader's read/write alternation relies on this.
- `ADDR` and `DATA_WR` are sampled only in IDLE. Changes during RD, WR or DONE are ignored.
- `DATA_RD` is not masked. The end-of-image marker word (0xFFFF) passes through unchanged; detecting it is the loader's job.
- Reset (asynchronous, any state), effective immediately:
  - state = IDLE
  - all `_N` outputs = 1
  - `SRAM_ADDR` = 0, `DATA_RD` = 0, `SRAM_done` = 0
  - DQ = hi-Z
  - An access interrupted by reset never produces `SRAM_done`.

## Timing
- Request sampled at clock edge E0:
  - access state lasts `WAIT_CYCLES` cycles, E0 to E(`WAIT_CYCLES`);
  - data is captured at E(`WAIT_CYCLES`);
  - `SRAM_done` is high for exactly one cycle, starting at E(`WAIT_CYCLES`).
- `DATA_RD` is valid in the same cycle as `SRAM_done`.
- Throughput: one access per `WAIT_CYCLES`+2 cycles, counting DONE and IDLE. With the default, the loader's read/write loop sustains one word every 4 cycles.
- All outputs come from registers; there is no combinational path from input to output.
- `SRAM_DQ` turnaround: the bus is driven only in WR. The DONE cycle between WR and any later RD provides one bus-idle cycle.

## Structure
- Shared package `sram_pkg`:
  - `SRAM_ADDR_W` = 20, `SRAM_DATA_W` = 16;
  - the `sram_state_t` enum {IDLE, RD, WR, DONE};
  - the default `WAIT_CYCLES`.
- No sub-module. The wait counter (4 bits) and the tri-state driver stay inline.
- The bench uses a behavioural async SRAM model, outside the RTL.

## Test plan
- Reset: assert `Reset` mid-cycle → all `_N` outputs = 1, DQ = Z, `DATA_RD` = 0x0000 and `SRAM_done` = 0 without waiting for a clock edge.
- Single read: model holds 0x1234 at 0x25801; raise `reading` with `ADDR`=0x25801 → OE_N low for exactly 2 cycles; one-cycle `SRAM_done`; `DATA_RD` = 0x1234.
- Loader loop: addresses 0x00000–0x00003 hold 0x0101, 0x0202, 0x0303, 0xFFFF; drive the read/drop/read pattern → 4 pulses, spaced 4 cycles apart, with matching data; 0xFFFF is returned unchanged.
- Priority: `reading` (0x00010) and `wr_req` (0x00020, 0xABCD) both high → read completes first, then the write. A later read of 0x00020 returns 0xABCD. WE_N is never low at the same time as OE_N.
- Write timing: write 0x5A5A to 0x7FFFF → DQ driven only during WR; WE_N high in the DONE cycle while `SRAM_ADDR` is still 0x7FFFF.
- Reset mid-RD: assert `Reset` in the 1st RD cycle → no `SRAM_done`, `DATA_RD` = 0. After release, a new read completes normally.
